data_cache: RTL

// Direct-mapped, write-through, no-write-allocate data cache between the CPU load/store path and Data_Memory.

---
 rtl/dcache_pkg.sv | 31 +++
 rtl/data_cache_if.sv | 36 +++
 rtl/dcache_line_store.sv | 49 ++++
 rtl/data_cache.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared geometry, FSM state type and address-split helper for the
// direct-mapped write-through data cache.
package dcache_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int LINES      = 8;
  localparam int WORDS      = 4;
  localparam int INDEX_W    = $clog2(LINES);
  localparam int OFFS_W     = $clog2(WORDS);
  localparam int TAG_W      = ADDR_WIDTH - 2 - OFFS_W - INDEX_W;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} dcache_state_t;

  // Packs exactly into the word address addr[ADDR_WIDTH-1:2]
  typedef struct packed {
    logic [TAG_W-1:0]   tag;
    logic [INDEX_W-1:0] index;
    logic [OFFS_W-1:0]  offset;
  } addr_fields_t;

  function automatic addr_fields_t addr_fields(input logic [ADDR_WIDTH-1:0] addr);
    addr_fields_t f;
    logic [1:0]   unused_byte_lane;
    unused_byte_lane = addr[1:0];
    f.tag    = addr[ADDR_WIDTH-1 -: TAG_W];
    f.index  = addr[2+OFFS_W +: INDEX_W];
    f.offset = addr[2 +: OFFS_W];
    return f;
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU load/store port and backing-memory req/ack port of the data cache.
// The cache takes the slave view; the core/memory environment takes master.
interface data_cache_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);

  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_stall;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/dcache_line_store.sv
// Tag, valid and data arrays of the cache: combinational read port, one
// synchronous word write and a tag/valid write for completing a fill.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_W-1:0]    rd_index,
  input  logic [OFFS_W-1:0]     rd_offset,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_WIDTH-1:0] rd_word,
  input  logic [INDEX_W-1:0]    wr_index,
  input  logic                  wr_en,
  input  logic [OFFS_W-1:0]     wr_offset,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  tv_we,
  input  logic [TAG_W-1:0]      tv_tag
);

  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_arr  [LINES];
  logic [DATA_WIDTH-1:0] data_arr [LINES][WORDS];

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_arr[rd_index];
  assign rd_word  = data_arr[rd_index][rd_offset];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (tv_we) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data contents are meaningless until valid is set, so no reset
  always_ff @(posedge clk) begin
    if (tv_we) begin
      tag_arr[wr_index] <= tv_tag;
    end
    if (wr_en) begin
      data_arr[wr_index][wr_offset] <= wr_data;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache between the
// single-cycle core load/store path and the backing data memory.
//
//   state | meaning
//   IDLE  | combinational lookup; load hits complete with no stall
//   FILL  | reading WORDS words of the missed line, one per mem_ack
//   WRITE | store written through to memory; cached word updated on hit
//   WDONE | one unstalled cycle so the core retires the store
module data_cache
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  data_cache_if.slave          bus,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  dcache_state_t         state_q;
  dcache_state_t         state_d;

  addr_fields_t          req_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [OFFS_W-1:0]     cnt_q;
  logic                  fill_done_q;

  logic [ADDR_WIDTH-1:0] look_addr;
  addr_fields_t          look;
  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  hit;
  logic                  idle_req;
  logic                  load_hit;
  logic                  load_miss;
  logic                  store_req;
  logic                  ack;
  logic                  last_word;
  logic                  fill_last;

  logic                  wr_en;
  logic [OFFS_W-1:0]     wr_offset;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  tv_we;

  // Outside IDLE the lookup tracks the latched request so WRITE can test its own hit
  assign look_addr = (state_q == IDLE) ? bus.cpu_addr : {req_q, 2'b00};
  assign look      = addr_fields(look_addr);

  assign hit       = rd_valid && (rd_tag == look.tag);
  assign idle_req  = (state_q == IDLE) && bus.cpu_req;
  assign load_hit  = idle_req && !bus.cpu_we && hit;
  assign load_miss = idle_req && !bus.cpu_we && !hit;
  assign store_req = idle_req && bus.cpu_we;

  assign ack       = bus.mem_ack && ((state_q == FILL) || (state_q == WRITE));
  assign last_word = (cnt_q == OFFS_W'(WORDS - 1));
  assign fill_last = (state_q == FILL) && ack && last_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load_miss) begin
          state_d = FILL;
        end else if (store_req) begin
          state_d = WRITE;
        end
      end
      FILL: begin
        if (fill_last) begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (ack) begin
          state_d = WDONE;
        end
      end
      WDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.cpu_rdata = rd_word;
    bus.cpu_stall = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state_q)
      IDLE: begin
        bus.cpu_stall = bus.cpu_req && (bus.cpu_we || !hit);
      end
      FILL: begin
        bus.cpu_stall = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_addr  = {req_q.tag, req_q.index, cnt_q, 2'b00};
      end
      WRITE: begin
        bus.cpu_stall = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {req_q, 2'b00};
        bus.mem_wdata = wdata_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      fill_done_q <= 1'b0;
    end else begin
      fill_done_q <= fill_last;
      if (load_miss) begin
        cnt_q <= '0;
      end else if ((state_q == FILL) && ack) begin
        cnt_q <= cnt_q + OFFS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_miss || store_req) begin
      req_q   <= look;
      wdata_q <= bus.cpu_wdata;
    end
  end

  // The hit right after a fill retires the access already counted as a miss
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (load_hit && !fill_done_q && (hit_count != '1)) begin
        hit_count <= hit_count + CNT_WIDTH'(1);
      end
      if (load_miss && (miss_count != '1)) begin
        miss_count <= miss_count + CNT_WIDTH'(1);
      end
    end
  end

  assign wr_en     = !rst && (((state_q == FILL) && ack) || ((state_q == WRITE) && ack && hit));
  assign wr_offset = (state_q == FILL) ? cnt_q : req_q.offset;
  assign wr_data   = (state_q == FILL) ? bus.mem_rdata : wdata_q;
  assign tv_we     = !rst && fill_last;

  dcache_line_store #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_line_store (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (look.index),
    .rd_offset (look.offset),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_word   (rd_word),
    .wr_index  (req_q.index),
    .wr_en     (wr_en),
    .wr_offset (wr_offset),
    .wr_data   (wr_data),
    .tv_we     (tv_we),
    .tv_tag    (req_q.tag)
  );

endmodule
